cdb_broadcaster: RTL

//  Transmit end of the common data bus (CDB). Collects completed results from NUM_SRC

---
 rtl/ooo_pkg.sv | 11 +
 rtl/cdb_broadcaster_if.sv | 26 ++
 rtl/cdb_src_fifo.sv | 50 +++++
 rtl/cdb_broadcaster.sv | 115 +++++++++++
 4 files changed

// File: rtl/ooo_pkg.sv
// Types and widths shared by the out-of-order core blocks that produce or snoop the CDB.
package ooo_pkg;
  localparam int ROB_IDX_W = 4;
  localparam int DATA_W    = 16;
  localparam int CDB_LANES = 4;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_index;
    logic [DATA_W-1:0]    result;
  } cdb_entry_t;
endpackage

// File: rtl/cdb_broadcaster_if.sv
// Result-producer side and CDB side of the broadcaster, grouped as one bundle.
interface cdb_broadcaster_if
  import ooo_pkg::*;
#(
  parameter int NUM_SRC = 6,
  parameter int LANES   = CDB_LANES
);
  logic [NUM_SRC-1:0]                in_valid;
  logic [NUM_SRC-1:0]                in_ready;
  logic [NUM_SRC-1:0][ROB_IDX_W-1:0] in_rob_index;
  logic [NUM_SRC-1:0][DATA_W-1:0]    in_result;
  logic [LANES-1:0]                  cdb_valid;
  logic [LANES-1:0][ROB_IDX_W-1:0]   cdb_rob_index;
  logic [LANES-1:0][DATA_W-1:0]      cdb_result;
  logic                              busy;

  modport master (
    output in_valid, in_rob_index, in_result,
    input  in_ready, cdb_valid, cdb_rob_index, cdb_result, busy
  );

  modport slave (
    input  in_valid, in_rob_index, in_result,
    output in_ready, cdb_valid, cdb_rob_index, cdb_result, busy
  );
endinterface

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO; flush empties it and overrides any same-cycle push/pop.
module cdb_src_fifo
  import ooo_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  cdb_entry_t       i_entry,
  output cdb_entry_t       o_entry,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty,
  output logic             o_full
);
  localparam int PTR_W = $clog2(DEPTH);

  cdb_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr, r_rd;
  logic [CNT_W-1:0] r_count;

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + PTR_W'(1);
      if (i_pop)  r_rd <= r_rd + PTR_W'(1);
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr] <= i_entry;
  end

  assign o_entry = r_mem[r_rd];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
endmodule

// File: rtl/cdb_broadcaster.sv
// CDB transmit end: per-source FIFOs, round-robin grant of up to LANES heads per cycle,
// registered lane outputs packed from lane 0.
module cdb_broadcaster
  import ooo_pkg::*;
#(
  parameter int NUM_SRC = 6,
  parameter int LANES   = CDB_LANES,
  parameter int DEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  cdb_broadcaster_if.slave bus
);
  localparam int SRC_W  = $clog2(NUM_SRC);
  localparam int LANE_W = $clog2(LANES + 1);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic [NUM_SRC-1:0] w_push, w_pop, w_grant, w_empty, w_full, w_ready, w_nonempty;
  cdb_entry_t         w_head  [NUM_SRC];
  logic [CNT_W-1:0]   w_count [NUM_SRC];

  logic [LANES-1:0]             w_lane_vld;
  cdb_entry_t [LANES-1:0]       w_lane_ent;
  logic                         w_any;
  logic [SRC_W-1:0]             w_last, w_rr_nxt;
  logic [SRC_W:0]               w_idx;
  logic [LANE_W-1:0]            w_cnt;

  logic [SRC_W-1:0]       r_rr_ptr;
  logic [LANES-1:0]       r_cdb_vld;
  cdb_entry_t [LANES-1:0] r_cdb_ent;

  // Ready is a function of the registered count only; a full FIFO refuses even if it pops.
  assign w_ready = {NUM_SRC{rst_n & ~flush}} & ~w_full;
  assign w_push  = bus.in_valid & w_ready;
  assign w_pop   = w_grant & {NUM_SRC{~flush}};

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    cdb_src_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push[s]),
      .i_pop   (w_pop[s]),
      .i_flush (flush),
      .i_entry ({bus.in_rob_index[s], bus.in_result[s]}),
      .o_entry (w_head[s]),
      .o_count (w_count[s]),
      .o_empty (w_empty[s]),
      .o_full  (w_full[s])
    );
    assign w_nonempty[s] = (w_count[s] != '0);
  end

  // Scan from rr_ptr with wraparound; each non-empty source takes the next free lane.
  always_comb begin
    w_grant    = '0;
    w_lane_vld = '0;
    w_lane_ent = '0;
    w_any      = 1'b0;
    w_last     = '0;
    w_cnt      = '0;
    w_idx      = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (SRC_W+1)'(k);
      if (w_idx >= (SRC_W+1)'(NUM_SRC)) w_idx = w_idx - (SRC_W+1)'(NUM_SRC);
      if (!w_empty[w_idx[SRC_W-1:0]] && (w_cnt < LANE_W'(LANES))) begin
        w_grant[w_idx[SRC_W-1:0]] = 1'b1;
        for (int l = 0; l < LANES; l++) begin
          if (w_cnt == LANE_W'(l)) begin
            w_lane_vld[l] = 1'b1;
            w_lane_ent[l] = w_head[w_idx[SRC_W-1:0]];
          end
        end
        w_cnt  = w_cnt + LANE_W'(1);
        w_last = w_idx[SRC_W-1:0];
        w_any  = 1'b1;
      end
    end
  end

  always_comb begin
    w_rr_nxt = r_rr_ptr;
    if (w_any) w_rr_nxt = (w_last == SRC_W'(NUM_SRC - 1)) ? '0 : w_last + SRC_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cdb_vld <= '0;
      r_cdb_ent <= '0;
      r_rr_ptr  <= '0;
    end else if (flush) begin
      r_cdb_vld <= '0;
      r_cdb_ent <= '0;
      r_rr_ptr  <= '0;
    end else begin
      r_cdb_vld <= w_lane_vld;
      r_cdb_ent <= w_lane_ent;
      r_rr_ptr  <= w_rr_nxt;
    end
  end

  always_comb begin
    bus.cdb_valid     = r_cdb_vld;
    bus.cdb_rob_index = '0;
    bus.cdb_result    = '0;
    for (int l = 0; l < LANES; l++) begin
      bus.cdb_rob_index[l] = r_cdb_ent[l].rob_index;
      bus.cdb_result[l]    = r_cdb_ent[l].result;
    end
  end

  assign bus.in_ready = w_ready;
  assign bus.busy     = |w_nonempty;
endmodule
